// File: rtl/ack_bus_pkg.sv
// Shared definitions for the ACK bus scheduler: source IDs, FSM states and
// the fixed-priority pick (CTRL > MEM > AES > SHA).
package ack_bus_pkg;

   localparam logic [1:0] SRC_MEM  = 2'b00;
   localparam logic [1:0] SRC_SHA  = 2'b01;
   localparam logic [1:0] SRC_AES  = 2'b10;
   localparam logic [1:0] SRC_CTRL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_RELEASE
   } state_t;

   // Request vector is indexed by source ID.
   function automatic logic [1:0] prio_pick(input logic [3:0] req);
      if (req[SRC_CTRL])     return SRC_CTRL;
      else if (req[SRC_MEM]) return SRC_MEM;
      else if (req[SRC_AES]) return SRC_AES;
      else                   return SRC_SHA;
   endfunction

endpackage

// File: rtl/ack_wait_counter.sv
// Per-source wait counter: counts cycles a request waits ungranted and
// flags when it has saturated at LIMIT.
module ack_wait_counter #(
   parameter int unsigned LIMIT = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req,
   input  logic clr,
   output logic sat
);

   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (!req || clr)
         cnt <= '0;
      else if (cnt != W'(LIMIT))
         cnt <= cnt + 1'b1;
   end

   assign sat = (cnt == W'(LIMIT));

endmodule

// File: rtl/ack_bus_scheduler.sv
// Registered owner of the shared ACK bus with a one-cycle release gap and
// age promotion. Optional grant hold timeout via ACK_SCHED_TIMEOUT_EN.
import ack_bus_pkg::*;

module ack_bus_scheduler #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned HOLD_MAX     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_mem,
   input  logic       req_sha,
   input  logic       req_aes,
   input  logic       req_ctrl,
   input  logic       ack_done,
   output logic       ack_ready_to_mem,
   output logic       ack_ready_to_sha,
   output logic       ack_ready_to_aes,
   output logic       ack_ready_to_ctrl,
   output logic [1:0] winner_source_id,
   output logic       ack_event,
   output logic       timeout_flag,
   output logic [1:0] timeout_src
);

   if (STARVE_LIMIT < 1 || HOLD_MAX < 1) begin : g_bad_param
      $error("ack_bus_scheduler: STARVE_LIMIT and HOLD_MAX must be >= 1");
   end

   state_t     state;
   logic [3:0] req_vec;
   logic [3:0] sat_vec;
   logic [3:0] starved;
   logic [3:0] grant_q;
   logic [3:0] issue_vec;
   logic [1:0] pick;
   logic       arb_en;
   logic       grantee_req;

   assign req_vec = {req_ctrl, req_aes, req_sha, req_mem};

   // Starved requesters pre-empt the normal priority order.
   always_comb begin
      starved     = req_vec & sat_vec;
      pick        = prio_pick((|starved) ? starved : req_vec);
      arb_en      = (state != ST_GRANT) && (|req_vec);
      issue_vec   = arb_en ? (4'b0001 << pick) : '0;
      grantee_req = |(req_vec & grant_q);
   end

   for (genvar i = 0; i < 4; i++) begin : g_wait
      ack_wait_counter #(.LIMIT(STARVE_LIMIT)) u_wait (
         .clk   (clk),
         .rst_n (rst_n),
         .req   (req_vec[i]),
         .clr   (grant_q[i] | issue_vec[i]),
         .sat   (sat_vec[i])
      );
   end

`ifdef ACK_SCHED_TIMEOUT_EN
   localparam int unsigned HW = $clog2(HOLD_MAX + 1);
   logic [HW-1:0] hold_cnt;
   logic          hold_expire;
   assign hold_expire = (hold_cnt == HW'(HOLD_MAX - 1));
`else
   assign timeout_flag = 1'b0;
   assign timeout_src  = 2'b00;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= ST_IDLE;
         grant_q          <= '0;
         ack_event        <= 1'b0;
         winner_source_id <= SRC_CTRL;
`ifdef ACK_SCHED_TIMEOUT_EN
         hold_cnt         <= '0;
         timeout_flag     <= 1'b0;
         timeout_src      <= 2'b00;
`endif
      end else begin
         case (state)
            ST_IDLE, ST_RELEASE: begin
               if (arb_en) begin
                  state            <= ST_GRANT;
                  grant_q          <= issue_vec;
                  ack_event        <= 1'b1;
                  winner_source_id <= pick;
`ifdef ACK_SCHED_TIMEOUT_EN
                  hold_cnt         <= '0;
`endif
               end else begin
                  state     <= ST_IDLE;
                  grant_q   <= '0;
                  ack_event <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (ack_done || !grantee_req) begin
                  state     <= ST_RELEASE;
                  grant_q   <= '0;
                  ack_event <= 1'b0;
               end
`ifdef ACK_SCHED_TIMEOUT_EN
               else if (hold_expire) begin
                  state     <= ST_RELEASE;
                  grant_q   <= '0;
                  ack_event <= 1'b0;
                  if (!timeout_flag) begin
                     timeout_flag <= 1'b1;
                     timeout_src  <= winner_source_id;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
`endif
            end
            default: begin
               state     <= ST_IDLE;
               grant_q   <= '0;
               ack_event <= 1'b0;
            end
         endcase
      end
   end

   assign ack_ready_to_mem  = grant_q[SRC_MEM];
   assign ack_ready_to_sha  = grant_q[SRC_SHA];
   assign ack_ready_to_aes  = grant_q[SRC_AES];
   assign ack_ready_to_ctrl = grant_q[SRC_CTRL];

endmodule
